// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle divider: FSM state encodings,
// handshake levels and the double-width result bus width.
package div_unit_pkg;

  // Two-bit state encoding: Free / ByZero / On / End.
  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  // Reset is active-low throughout the pipeline.
  localparam logic RST_ENABLE          = 1'b0;
  localparam logic DIV_RESULT_READY    = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START           = 1'b1;
  localparam logic DIV_STOP            = 1'b0;
  localparam int   DOUBLE_REG_W        = 64;

endpackage

// File: rtl/div_unit_step.sv
// One restoring division iteration: shift {rem, dvd} left by one, try to
// subtract the divisor, keep the difference when it is non-negative and
// shift the resulting quotient bit into the low end of dvd.
module div_unit_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] dvd,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] dvd_next
);

  // The shifted remainder needs one extra bit; its top bit after the
  // subtraction is the sign of the trial difference.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           q_bit;

  // Trial subtraction and restore decision.
  always_comb begin
    shifted = {rem, dvd[WIDTH-1]};
    trial   = shifted - {1'b0, divisor};
    q_bit   = ~trial[WIDTH];
    if (q_bit) begin
      rem_next = trial[WIDTH-1:0];
    end else begin
      rem_next = shifted[WIDTH-1:0];
    end
    dvd_next = {dvd[WIDTH-2:0], q_bit};
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU in EX.
// result_o = {remainder, quotient}; HI takes the remainder, LO the quotient.
// Optional macro DIV_ZERO_FLAG_EN adds div_zero_o, high while the result
// being presented came from a zero divisor.
//
// Handshake: EX raises start_i with valid operands and holds it high until it
// has consumed the result; ready_o rises once and result_o stays valid while
// start_i remains high; dropping start_i returns the unit to idle on the next
// edge. annul_i aborts a division still in progress and is ignored once the
// result is presented.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic               div_zero_o
`endif
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

  // FSM state is kept as a named enum so checkers can bind to it directly.
  div_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] rem, rem_nxt;
  logic [WIDTH-1:0] dvd, dvd_nxt;
  logic [WIDTH-1:0] divisor, divisor_nxt;
  logic             neg_q, neg_q_nxt;
  logic             neg_r, neg_r_nxt;
  logic [2*WIDTH-1:0] result_nxt;
  logic             ready_nxt;
`ifdef DIV_ZERO_FLAG_EN
  logic             zero_nxt;
`endif

  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_dvd;
  logic             sign1;
  logic             sign2;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;

  div_unit_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem      (rem),
    .dvd      (dvd),
    .divisor  (divisor),
    .rem_next (step_rem),
    .dvd_next (step_dvd)
  );

  // Operand magnitudes and final sign correction.
  always_comb begin
    sign1    = signed_div_i & opdata1_i[WIDTH-1];
    sign2    = signed_div_i & opdata2_i[WIDTH-1];
    mag1     = sign1 ? (~opdata1_i + 1'b1) : opdata1_i;
    mag2     = sign2 ? (~opdata2_i + 1'b1) : opdata2_i;
    quot_fix = neg_q ? (~dvd + 1'b1) : dvd;
    rem_fix  = neg_r ? (~rem + 1'b1) : rem;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    rem_nxt     = rem;
    dvd_nxt     = dvd;
    divisor_nxt = divisor;
    neg_q_nxt   = neg_q;
    neg_r_nxt   = neg_r;
    result_nxt  = result_o;
    ready_nxt   = ready_o;
`ifdef DIV_ZERO_FLAG_EN
    zero_nxt    = div_zero_o;
`endif
    case (state)
      DIV_FREE: begin
        result_nxt = '0;
        ready_nxt  = DIV_RESULT_NOT_READY;
        cnt_nxt    = '0;
`ifdef DIV_ZERO_FLAG_EN
        zero_nxt   = 1'b0;
`endif
        if (start_i == DIV_START && !annul_i) begin
          if (opdata2_i == '0) begin
            state_nxt = DIV_BYZERO;
          end else begin
            state_nxt   = DIV_ON;
            rem_nxt     = '0;
            dvd_nxt     = mag1;
            divisor_nxt = mag2;
            neg_q_nxt   = sign1 ^ sign2;
            neg_r_nxt   = sign1;
          end
        end
      end
      DIV_BYZERO: begin
        // Zero divisor waits two cycles so ready_o rises two edges after
        // acceptance.
        if (annul_i) begin
          state_nxt = DIV_FREE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_W'(1)) begin
          state_nxt  = DIV_END;
          result_nxt = '0;
          ready_nxt  = DIV_RESULT_READY;
`ifdef DIV_ZERO_FLAG_EN
          zero_nxt   = 1'b1;
`endif
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DIV_ON: begin
        if (annul_i) begin
          state_nxt = DIV_FREE;
          cnt_nxt   = '0;
        end else if (cnt == LAST_CNT) begin
          state_nxt  = DIV_END;
          result_nxt = {rem_fix, quot_fix};
          ready_nxt  = DIV_RESULT_READY;
        end else begin
          rem_nxt = step_rem;
          dvd_nxt = step_dvd;
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DIV_END: begin
        if (start_i == DIV_STOP) begin
          state_nxt  = DIV_FREE;
          result_nxt = '0;
          ready_nxt  = DIV_RESULT_NOT_READY;
          cnt_nxt    = '0;
`ifdef DIV_ZERO_FLAG_EN
          zero_nxt   = 1'b0;
`endif
        end
      end
      default: begin
        state_nxt = DIV_FREE;
      end
    endcase
  end

  // State, datapath and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state    <= DIV_FREE;
      cnt      <= '0;
      rem      <= '0;
      dvd      <= '0;
      divisor  <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
      div_zero_o <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      rem      <= rem_nxt;
      dvd      <= dvd_nxt;
      divisor  <= divisor_nxt;
      neg_q    <= neg_q_nxt;
      neg_r    <= neg_r_nxt;
      result_o <= result_nxt;
      ready_o  <= ready_nxt;
`ifdef DIV_ZERO_FLAG_EN
      div_zero_o <= zero_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: hand-computed quotient/remainder pairs,
// latency counts, hold/release behaviour, annul and asynchronous reset.
module tb_div_unit;

  localparam int WIDTH = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              signed_div;
  logic [WIDTH-1:0]  op1;
  logic [WIDTH-1:0]  op2;
  logic              start;
  logic              annul;
  logic [2*WIDTH-1:0] result;
  logic              ready;
`ifdef DIV_ZERO_FLAG_EN
  logic              div_zero;
`endif

  int total = 0;
  int bad   = 0;
  int lat;
  logic seen_ready;

  div_unit #(
    .WIDTH(WIDTH),
    .CNT_W(6)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
`ifdef DIV_ZERO_FLAG_EN
    ,
    .div_zero_o   (div_zero)
`endif
  );

  // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and pass the acceptance edge E0, then scramble the
  // operand inputs to show they are no longer looked at.
  task automatic launch(input logic sgn, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    signed_div = sgn;
    op1        = a;
    op2        = b;
    annul      = 1'b0;
    start      = 1'b1;
    tick();
    op1        = $urandom;
    op2        = $urandom_range(1, 1000);
    signed_div = ~sgn;
  endtask

  // Count edges after E0 until ready_o rises (bounded).
  task automatic wait_ready(input string tag, input int exp_lat);
    lat = 0;
    while (ready !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
  endtask

  // Full transaction: accept, wait, check result, hold, release.
  task automatic run_div(input string tag, input logic sgn, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [63:0] exp_res,
                         input int exp_lat, input logic exp_zero);
    launch(sgn, a, b);
    wait_ready(tag, exp_lat);
    check({tag, " result"}, result, exp_res);
`ifdef DIV_ZERO_FLAG_EN
    check({tag, " div_zero"}, 64'(div_zero), 64'(exp_zero));
`else
    if (exp_zero) check({tag, " zero result"}, result, 64'h0);
`endif
    // Result must hold while start stays high; annul is ignored here.
    annul = 1'b1;
    tick();
    tick();
    check({tag, " hold ready"}, 64'(ready), 64'h1);
    check({tag, " hold result"}, result, exp_res);
    annul = 1'b0;
    start = 1'b0;
    tick();
    check({tag, " release ready"}, 64'(ready), 64'h0);
    check({tag, " release result"}, result, 64'h0);
`ifdef DIV_ZERO_FLAG_EN
    check({tag, " release div_zero"}, 64'(div_zero), 64'h0);
`endif
  endtask

  initial begin
    rst        = 1'b1;
    signed_div = 1'b0;
    op1        = '0;
    op2        = '0;
    start      = 1'b0;
    annul      = 1'b0;
    #1 rst = 1'b0;
    #11;
    check("reset ready", 64'(ready), 64'h0);
    check("reset result", result, 64'h0);
`ifdef DIV_ZERO_FLAG_EN
    check("reset div_zero", 64'(div_zero), 64'h0);
`endif
    #2 rst = 1'b1;
    tick();
    tick();
    check("idle ready", 64'(ready), 64'h0);

    // Main function across sign modes.
    run_div("u100_7",    1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 33, 1'b0);
    run_div("s-7_2",     1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, 33, 1'b0);
    run_div("s7_-2",     1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 33, 1'b0);
    run_div("uffff_1",   1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 33, 1'b0);
    run_div("uffff_-1",  1'b0, 32'hFFFFFFF9,   32'hFFFFFFFE,   64'hFFFFFFF9_00000000, 33, 1'b0);
    run_div("s_ovf",     1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 33, 1'b0);
    run_div("div0",      1'b0, 32'd5,          32'd0,          64'h0,                 2,  1'b1);

    // Annul after 10 ON cycles, restart one cycle after the abort.
    launch(1'b0, 32'd1000, 32'd3);
    seen_ready = 1'b0;
    repeat (10) begin
      tick();
      seen_ready |= ready;
    end
    annul = 1'b1;
    start = 1'b0;
    tick();
    seen_ready |= ready;
    annul = 1'b0;
    tick();
    seen_ready |= ready;
    check("annul no ready", 64'(seen_ready), 64'h0);
    check("annul result", result, 64'h0);
    run_div("after_annul", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33, 1'b0);

    // Annul held in FREE blocks acceptance.
    signed_div = 1'b0;
    op1        = 32'd50;
    op2        = 32'd6;
    start      = 1'b1;
    annul      = 1'b1;
    repeat (3) tick();
    check("free annul blocks", 64'(ready), 64'h0);
    annul = 1'b0;
    tick();
    wait_ready("free annul then go", 33);
    check("free annul then go result", result, 64'h00000002_00000008);
    start = 1'b0;
    tick();

    // Asynchronous reset in the middle of ON, between edges.
    launch(1'b0, 32'd100, 32'd7);
    repeat (20) tick();
    #3 rst = 1'b0;
    #1;
    check("midon reset ready", 64'(ready), 64'h0);
    check("midon reset result", result, 64'h0);
    start = 1'b0;
    #3 rst = 1'b1;
    seen_ready = 1'b0;
    repeat (5) begin
      tick();
      seen_ready |= ready;
    end
    check("post reset idle", 64'(seen_ready), 64'h0);
    run_div("post_reset", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33, 1'b0);

    // Asynchronous reset while a result is being presented.
    launch(1'b0, 32'd100, 32'd7);
    wait_ready("end reset pre", 33);
    #2 rst = 1'b0;
    #1;
    check("end reset ready", 64'(ready), 64'h0);
    check("end reset result", result, 64'h0);
    start = 1'b0;
    #2 rst = 1'b1;
    tick();
    tick();
    check("end reset idle", 64'(ready), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
